// File: rtl/fixed_priority_arbiter_pkg.sv
// Shared defaults and the lowest-set-bit helper for the fixed-priority arbiter.
// The reference model in the bench uses the same helper.
package fixed_priority_arbiter_pkg;

   localparam int DEF_NUM_REQ      = 4;
   localparam int DEF_STARVE_LIMIT = 16;
   localparam int MAX_REQ          = 32;

   // Isolates the lowest set bit; callers zero-extend narrower vectors.
   function automatic logic [MAX_REQ-1:0] lsb_onehot(input logic [MAX_REQ-1:0] vec);
      return vec & (~vec + MAX_REQ'(1));
   endfunction

endpackage

// File: rtl/fixed_priority_arbiter_onehot_to_bin.sv
// One-hot (or zero) vector to binary index plus valid flag.
// An all-zero input yields index 0 with vld low.
module onehot_to_bin #(
   parameter  int WIDTH = 4,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

   // OR of the indices of set bits is exact for a one-hot input.
   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) begin
            idx = idx | IDX_W'(i);
         end
      end
   end

   assign vld = |onehot;

endmodule

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority arbiter: combinational lowest-index grant, registered last grant,
// and optional starvation monitor enabled by FIXED_PRIORITY_ARBITER_STARVE_MON_EN.
module fixed_priority_arbiter
   import fixed_priority_arbiter_pkg::*;
#(
   parameter  int NUM_REQ      = DEF_NUM_REQ,
   parameter  int STARVE_LIMIT = DEF_STARVE_LIMIT,
   localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               allow_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               gnt_vld_o,
   output logic [NUM_REQ-1:0] last_gnt_o,
   output logic [NUM_REQ-1:0] starve_o
);

   if (NUM_REQ < 1) begin : g_bad_num_req
      $error("fixed_priority_arbiter: NUM_REQ must be >= 1");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("fixed_priority_arbiter: STARVE_LIMIT must be >= 1");
   end

   logic [NUM_REQ-1:0] last_gnt_q;

   // Two's-complement trick isolates the lowest set request; no state involved.
   assign gnt_o = allow_i ? (req_i & (~req_i + NUM_REQ'(1))) : '0;

   onehot_to_bin #(
      .WIDTH (NUM_REQ)
   ) u_onehot_to_bin (
      .onehot (gnt_o),
      .idx    (gnt_idx_o),
      .vld    (gnt_vld_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_gnt_q <= '0;
      end else begin
         last_gnt_q <= gnt_o;
      end
   end

   assign last_gnt_o = last_gnt_q;

`ifdef FIXED_PRIORITY_ARBITER_STARVE_MON_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q [NUM_REQ];

   // allow_i low leaves gnt_o clear, so it counts as an ungranted cycle.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rst_i) begin
            starve_cnt_q[i] <= '0;
         end else if (req_i[i] && !gnt_o[i]) begin
            if (starve_cnt_q[i] != CNT_MAX) begin
               starve_cnt_q[i] <= starve_cnt_q[i] + CNT_W'(1);
            end
         end else begin
            starve_cnt_q[i] <= '0;
         end
      end
   end

   always_comb begin
      starve_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         starve_o[i] = (starve_cnt_q[i] == CNT_MAX);
      end
   end
`else
   assign starve_o = '0;
`endif

endmodule

// File: tb/tb_fixed_priority_arbiter.sv
// Scoreboard bench for fixed_priority_arbiter: directed test-plan vectors,
// starvation sequence, and randomised allow/request traffic.
module tb_fixed_priority_arbiter;
   import fixed_priority_arbiter_pkg::*;

   localparam int NR = 4;
   localparam int SL = 16;

   typedef struct packed {
      logic [NR-1:0] gnt;
      logic [1:0]    idx;
      logic          vld;
   } comb_exp_t;

   typedef struct packed {
      logic [NR-1:0] last;
      logic [NR-1:0] starve;
   } reg_exp_t;

   logic          clk_i   = 1'b0;
   logic          rst_i   = 1'b1;
   logic          allow_i = 1'b0;
   logic [NR-1:0] req_i   = '0;
   logic [NR-1:0] gnt_o;
   logic [1:0]    gnt_idx_o;
   logic          gnt_vld_o;
   logic [NR-1:0] last_gnt_o;
   logic [NR-1:0] starve_o;

   int n_cmp = 0;
   int n_bad = 0;
   int m_cnt [NR];

   comb_exp_t q_comb [$];
   reg_exp_t  q_reg  [$];

   always #5 clk_i = ~clk_i;

   fixed_priority_arbiter #(
      .NUM_REQ      (NR),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .allow_i    (allow_i),
      .req_i      (req_i),
      .gnt_o      (gnt_o),
      .gnt_idx_o  (gnt_idx_o),
      .gnt_vld_o  (gnt_vld_o),
      .last_gnt_o (last_gnt_o),
      .starve_o   (starve_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check combinational outputs, then registered ones.
   task automatic step(input logic a, input logic [NR-1:0] r, input logic rs);
      logic [MAX_REQ-1:0] wide;
      logic [NR-1:0]      g;
      logic [1:0]         ix;
      logic               found;
      comb_exp_t          ce;
      reg_exp_t           re;

      @(negedge clk_i);
      allow_i = a;
      req_i   = r;
      rst_i   = rs;

      wide  = lsb_onehot(MAX_REQ'(r));
      g     = a ? wide[NR-1:0] : '0;
      ix    = '0;
      found = 1'b0;
      for (int i = 0; i < NR; i++) begin
         if (g[i] && !found) begin
            ix    = 2'(i);
            found = 1'b1;
         end
      end
      q_comb.push_back('{gnt: g, idx: ix, vld: found});

      for (int i = 0; i < NR; i++) begin
         if (rs) m_cnt[i] = 0;
         else if (r[i] && !g[i]) m_cnt[i] = (m_cnt[i] < SL) ? m_cnt[i] + 1 : SL;
         else m_cnt[i] = 0;
      end
      re.last = rs ? '0 : g;
      for (int i = 0; i < NR; i++) begin
`ifdef FIXED_PRIORITY_ARBITER_STARVE_MON_EN
         re.starve[i] = (m_cnt[i] == SL);
`else
         re.starve[i] = 1'b0;
`endif
      end
      q_reg.push_back(re);

      #1;
      if (q_comb.size() == 0) begin
         chk("comb_queue_empty", 32'd0, 32'd1);
      end else begin
         ce = q_comb.pop_front();
         chk("gnt", 32'(gnt_o), 32'(ce.gnt));
         chk("gnt_idx", 32'(gnt_idx_o), 32'(ce.idx));
         chk("gnt_vld", 32'(gnt_vld_o), 32'(ce.vld));
      end

      @(posedge clk_i);
      #1;
      if (q_reg.size() == 0) begin
         chk("reg_queue_empty", 32'd0, 32'd1);
      end else begin
         re = q_reg.pop_front();
         chk("last_gnt", 32'(last_gnt_o), 32'(re.last));
         chk("starve", 32'(starve_o), 32'(re.starve));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic exp_starve1;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;

      step(1'b1, 4'b0000, 1'b1);
      step(1'b1, 4'b0000, 1'b1);
      chk("rst_last_gnt", 32'(last_gnt_o), 32'd0);
      chk("rst_starve", 32'(starve_o), 32'd0);

      step(1'b1, 4'b1010, 1'b0);
      chk("tp1_gnt", 32'(gnt_o), 32'b0010);
      chk("tp1_idx", 32'(gnt_idx_o), 32'd1);
      chk("tp1_vld", 32'(gnt_vld_o), 32'd1);
      chk("tp1_last", 32'(last_gnt_o), 32'b0010);

      step(1'b0, 4'b1111, 1'b0);
      chk("tp2_gnt_blocked", 32'(gnt_o), 32'd0);
      chk("tp2_vld_blocked", 32'(gnt_vld_o), 32'd0);
      chk("tp2_idx_blocked", 32'(gnt_idx_o), 32'd0);
      step(1'b1, 4'b1111, 1'b0);
      chk("tp2_gnt_allowed", 32'(gnt_o), 32'b0001);

      step(1'b1, 4'b0000, 1'b0);
      chk("tp3_gnt_none", 32'(gnt_o), 32'd0);
      step(1'b1, 4'b1000, 1'b0);
      chk("tp3_gnt_top", 32'(gnt_o), 32'b1000);
      chk("tp3_idx_top", 32'(gnt_idx_o), 32'd3);

      step(1'b1, 4'b0110, 1'b1);
      chk("rst_mid_last", 32'(last_gnt_o), 32'd0);
      chk("rst_mid_starve", 32'(starve_o), 32'd0);
      chk("rst_mid_gnt", 32'(gnt_o), 32'b0010);

      step(1'b1, 4'b0011, 1'b1);
      for (int k = 0; k < SL - 1; k++) step(1'b1, 4'b0011, 1'b0);
      chk("starve_before_limit", 32'(starve_o), 32'd0);
      step(1'b1, 4'b0011, 1'b0);
`ifdef FIXED_PRIORITY_ARBITER_STARVE_MON_EN
      exp_starve1 = 1'b1;
`else
      exp_starve1 = 1'b0;
`endif
      chk("starve1_at_limit", 32'(starve_o[1]), 32'(exp_starve1));
      chk("starve0_at_limit", 32'(starve_o[0]), 32'd0);
      step(1'b1, 4'b0010, 1'b0);
      chk("starve_gnt_req1", 32'(gnt_o), 32'b0010);
      chk("starve1_cleared", 32'(starve_o[1]), 32'd0);

      for (int k = 0; k < 1000; k++) begin
         step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fixed_priority_arbiter.md
Name: fixed_priority_arbiter

Overview:
- Parameterised fixed-priority arbiter that grants at most one of NUM_REQ requesters per cycle. The lowest index has the highest priority.
- The grant path is purely combinational (zero latency) and gated by a global allow_i enable.
- A clocked side-band provides a registered copy of the last grant and optional per-requester starvation monitoring.
- Used wherever shared resources (issue ports, bus masters, write-back lanes) need deterministic static priority.

Parameters:
- NUM_REQ, 4, number of requesters; legal range ≥1.
- STARVE_LIMIT, 16, cycles a request may wait ungranted before its starve flag asserts; ≥1.
- IDX_W, $clog2(NUM_REQ) (min 1), derived localparam; width of the grant index.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- allow_i  input  1  arbitration enable; 0 forces no grant.
- req_i  input  NUM_REQ  request vector, bit i = requester i.
- gnt_o  output  NUM_REQ  one-hot (or zero) grant, combinational.
- gnt_idx_o  output  IDX_W  binary index of the granted requester; 0 when gnt_vld_o=0.
- gnt_vld_o  output  1  OR-reduction of gnt_o.
- last_gnt_o  output  NUM_REQ  gnt_o registered on the previous clock edge.
- starve_o  output  NUM_REQ  per-requester starvation flag (optional feature).

Behaviour:
- Combinational grant:
  - gnt_o = allow_i ? (req_i & (~req_i + 1)) : 0, i.e. the lowest-index set bit of req_i.
  - gnt_o has no clock or reset dependency.
  - gnt_o is valid in the same cycle that req_i and allow_i change.
- Invariants:
  - popcount(gnt_o) ≤ 1.
  - gnt_o ⊆ req_i.
  - allow_i=0 → gnt_o=0.
  - req_i=0 → gnt_o=0.
  - The index of the first set bit of gnt_o equals the index of the first set bit of req_i whenever allow_i=1.
- gnt_idx_o / gnt_vld_o are combinational and derived from gnt_o; gnt_idx_o=0 when there is no grant.
- last_gnt_o:
  - Loaded with gnt_o at every rising edge.
  - Synchronous reset to 0; reset has priority over the load.
- No internal arbitration state: a fixed priority does not rotate.
- A requester that holds req high keeps its grant as long as no lower index requests.
- Simultaneous requests: the lowest index wins every cycle; higher indices may starve (this is by design; see the optional feature).
- Reset mid-operation: the combinational grant continues to follow the inputs. Only the registered outputs and counters clear.

Optional Feature:
- Macro: FIXED_PRIORITY_ARBITER_STARVE_MON_EN.
- Enabled:
  - One saturating counter per requester, width $clog2(STARVE_LIMIT+1).
  - Each edge: if rst_i, clear. Else if req_i[i]=1 and gnt_o[i]=0, increment (saturating at STARVE_LIMIT). Else clear.
  - starve_o[i] = (counter[i] == STARVE_LIMIT), registered; it deasserts on the edge after the grant or after the request drops.
  - An allow_i=0 cycle counts as an ungranted cycle for every active request.
- Disabled:
  - No counters are synthesised; starve_o is tied to 0.
  - The port list is unchanged.

Decomposition:
- Shared package fixed_priority_arbiter_pkg holds:
  - the default NUM_REQ;
  - the default STARVE_LIMIT;
  - the helper function lsb_onehot(vector), reused by the bench as a reference model.
- One natural sub-module, onehot_to_bin: converts gnt_o to gnt_idx_o and gnt_vld_o, with WIDTH set by NUM_REQ.

Test Plan:
- allow_i=1, req_i=4'b1010 → gnt_o=4'b0010, gnt_idx_o=1, gnt_vld_o=1 in the same cycle; last_gnt_o=4'b0010 after the next edge.
- allow_i=0, req_i=4'b1111 → gnt_o=0, gnt_vld_o=0, gnt_idx_o=0; allow_i=1 → gnt_o=4'b0001.
- allow_i=1, req_i=4'b0000 → gnt_o=0; req_i=4'b1000 → gnt_o=4'b1000, gnt_idx_o=3.
- Random: 1000 cycles of random allow_i and req_i; each cycle check gnt_o against lsb_onehot and the allow gating, with zero violations.
- rst_i=1 for 1 edge with req_i=4'b0110 and allow_i=1 → last_gnt_o=0 and starve_o=0 after the edge, while gnt_o=4'b0010 throughout.
- With the macro defined, STARVE_LIMIT=16, req_i=4'b0011 held and allow_i=1:
  - starve_o[1] rises after 16 edges; starve_o[0] stays 0.
  - Dropping req_i[0] grants requester 1, and starve_o[1] clears on the following edge.
- Without the macro, the same stimulus gives starve_o=0.
